// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the 3x3 window path (read and write sides).
package conv_pkg;
    localparam int PIX_W  = 8;
    localparam int LINE_W = 8;
    localparam int ROWS   = 8;

    // The line buffer ring holds at most four complete lines.
    localparam logic [2:0] AVAIL_MAX = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EMIT    = 3'd1,
        SKIP    = 3'd2,
        ROW_END = 3'd3,
        DONE    = 3'd4
    } state_t;
endpackage

// File: rtl/line_credit.sv
// Counts complete lines held in the line buffers; saturates at AVAIL_MAX and flags overflow.
module line_credit (
    input  logic       clk,
    input  logic       rst,
    input  logic       line_done,
    input  logic       line_consumed,
    output logic [2:0] avail,
    output logic       overflow
);
    import conv_pkg::*;

    always_ff @(posedge clk) begin
        if (rst) begin
            avail    <= '0;
            overflow <= 1'b0;
        end else if (line_done && !line_consumed) begin
            if (avail == AVAIL_MAX)
                overflow <= 1'b1;
            else
                avail <= avail + 3'd1;
        end else if (line_consumed && !line_done && avail != 3'd0) begin
            avail <= avail - 3'd1;
        end
    end
endmodule

// File: rtl/window_reader.sv
// Reads 3x3 windows out of three line buffers and hands them over a valid/ready port.
// Optional stall statistic: define WINDOW_READER_STATS_EN.
module window_reader #(
    parameter int PIX_W  = conv_pkg::PIX_W,
    parameter int LINE_W = conv_pkg::LINE_W,
    parameter int ROWS   = conv_pkg::ROWS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               line_done,
    input  logic [3*PIX_W-1:0] lb0_data,
    input  logic [3*PIX_W-1:0] lb1_data,
    input  logic [3*PIX_W-1:0] lb2_data,
    output logic               lb_oe,
    output logic               line_consumed,
    output logic [9*PIX_W-1:0] win_data,
    output logic               win_valid,
    input  logic               win_ready,
    output logic               frame_done,
    output logic               overflow,
    output logic [15:0]        stall_cnt
);
    import conv_pkg::*;

    localparam int CW = $clog2(LINE_W);
    localparam int RW = $clog2(ROWS);

    state_t             state;
    logic [CW-1:0]      col_cnt;
    logic [RW-1:0]      row_cnt;
    logic               skip_cnt;
    logic               vld_q, lc_q, fd_q;
    logic [9*PIX_W-1:0] data_q;
    logic [2:0]         avail;
    logic               capture;

    line_credit u_credit (
        .clk          (clk),
        .rst          (rst),
        .line_done    (line_done),
        .line_consumed(lc_q),
        .avail        (avail),
        .overflow     (overflow)
    );

    // A new window may overwrite the output register only once the old one is taken.
    assign capture = (state == EMIT) && (avail >= 3'd3) && (!vld_q || win_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            col_cnt  <= '0;
            row_cnt  <= '0;
            skip_cnt <= 1'b0;
            vld_q    <= 1'b0;
            data_q   <= '0;
            lc_q     <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            lc_q <= 1'b0;
            fd_q <= 1'b0;
            if (capture) begin
                data_q <= {lb0_data, lb1_data, lb2_data};
                vld_q  <= 1'b1;
            end else if (win_ready) begin
                vld_q  <= 1'b0;
            end
            case (state)
                IDLE: if (start) begin
                    state   <= EMIT;
                    row_cnt <= '0;
                    col_cnt <= '0;
                end
                EMIT: if (capture) begin
                    col_cnt <= col_cnt + CW'(1);
                    if (col_cnt == CW'(LINE_W - 3)) begin
                        state    <= SKIP;
                        skip_cnt <= 1'b0;
                    end
                end
                // Two extra pointer steps wrap the read pointer back to column 0.
                SKIP: begin
                    skip_cnt <= 1'b1;
                    if (skip_cnt) begin
                        state <= ROW_END;
                        lc_q  <= 1'b1;
                    end
                end
                ROW_END: begin
                    row_cnt <= row_cnt + RW'(1);
                    col_cnt <= '0;
                    state   <= (row_cnt == RW'(ROWS - 3)) ? DONE : EMIT;
                end
                DONE: if (!vld_q) begin
                    fd_q  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign lb_oe         = !rst && (capture || state == SKIP);
    assign win_valid     = vld_q && !rst;
    assign win_data      = rst ? '0 : data_q;
    assign line_consumed = lc_q && !rst;
    assign frame_done    = fd_q && !rst;

`ifdef WINDOW_READER_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && start))
            stall_q <= '0;
        else if (vld_q && !win_ready && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end

    assign stall_cnt = rst ? '0 : stall_q;
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_window_reader.sv
// Bench for window_reader: cycle vector table, hand corner sequences and randomized frames
// checked against a frame-level window list and a line-buffer environment model.
module tb_window_reader;
    import conv_pkg::*;

    localparam int WIN_W = 9 * PIX_W;
    localparam int NWIN  = (ROWS - 2) * (LINE_W - 2);

    logic               clk, rst, start, line_done, win_ready;
    logic [3*PIX_W-1:0] lb0_data, lb1_data, lb2_data;
    logic               lb_oe, line_consumed, win_valid, frame_done, overflow;
    logic [WIN_W-1:0]   win_data;
    logic [15:0]        stall_cnt;

    window_reader #(.PIX_W(PIX_W), .LINE_W(LINE_W), .ROWS(ROWS)) dut (
        .clk(clk), .rst(rst), .start(start), .line_done(line_done),
        .lb0_data(lb0_data), .lb1_data(lb1_data), .lb2_data(lb2_data),
        .lb_oe(lb_oe), .line_consumed(line_consumed), .win_data(win_data),
        .win_valid(win_valid), .win_ready(win_ready), .frame_done(frame_done),
        .overflow(overflow), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment: frame image, lines written, lines released, buffer read pointer.
    logic [PIX_W-1:0] pix [ROWS][LINE_W];
    int written, cons, rp;
    logic [WIN_W-1:0] exp_q [$];
    int n_cmp, n_err, n_acc, n_lc, n_fd;

    logic s_oe, s_vld, s_lc, s_fd, s_ov, prev_hold;
    logic [WIN_W-1:0] s_data, prev_data;
    logic [15:0] s_sc;
    int s_av, s_st;

    typedef struct {
        logic rs, st, ld, rdy;
        logic oe, vld, lc, fd, zero;
        int   av, sc;
    } vec_t;
    vec_t tv [$];

    function automatic int sc(input int n);
`ifdef WINDOW_READER_STATS_EN
        return n;
`else
        return 0;
`endif
    endfunction

    function automatic logic [PIX_W-1:0] px(input int r, input int c);
        if (r < ROWS && c < LINE_W) return pix[r][c];
        return '0;
    endfunction

    function automatic logic [3*PIX_W-1:0] row3(input int r, input int c);
        return {px(r, c), px(r, c + 1), px(r, c + 2)};
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic new_frame();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < LINE_W; c++)
                pix[r][c] = PIX_W'($urandom);
        exp_q.delete();
        for (int r = 0; r < ROWS - 2; r++)
            for (int c = 0; c < LINE_W - 2; c++)
                exp_q.push_back({row3(r, c), row3(r + 1, c), row3(r + 2, c)});
        n_acc = 0; n_lc = 0; n_fd = 0;
    endtask

    // One clock: drive at negedge, sample just after, advance the environment at posedge.
    task automatic cycle(input logic rs, input logic st, input logic ld, input logic rdy);
        @(negedge clk);
        rst = rs; start = st; line_done = ld; win_ready = rdy;
        lb0_data = row3(cons, rp);
        lb1_data = row3(cons + 1, rp);
        lb2_data = row3(cons + 2, rp);
        #1;
        s_oe = lb_oe; s_vld = win_valid; s_data = win_data; s_lc = line_consumed;
        s_fd = frame_done; s_sc = stall_cnt; s_ov = overflow;
        s_av = int'(dut.u_credit.avail); s_st = int'(dut.state);
        if (prev_hold && !rs) begin
            check("hold_valid", s_vld, 1'b1);
            check("hold_data", s_data, prev_data);
        end
        if (s_oe && !rs) check("lines_present", (written - cons >= 3), 1'b1);
        if (s_vld && rdy) begin
            n_acc++;
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL win_extra: got %0h, expected no window", s_data);
            end else begin
                check("win_data", s_data, exp_q.pop_front());
            end
        end
        if (s_lc) n_lc++;
        if (s_fd) n_fd++;
        prev_hold = s_vld && !rdy;
        prev_data = s_data;
        @(posedge clk);
        if (rs) begin
            written = 0; cons = 0; rp = 0; prev_hold = 1'b0;
            exp_q.delete();
        end else begin
            if (s_oe) rp = (rp + 1) % LINE_W;
            if (s_lc) cons++;
            if (ld) written++;
        end
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        n_acc = 0; n_lc = 0; n_fd = 0;
    endtask

    task automatic add(input logic rs, st, ld, rdy, oe, vld, lc, fd, zero,
                       input int av, input int scv, input int n);
        vec_t v;
        v.rs = rs; v.st = st; v.ld = ld; v.rdy = rdy;
        v.oe = oe; v.vld = vld; v.lc = lc; v.fd = fd; v.zero = zero;
        v.av = av; v.sc = scv;
        repeat (n) tv.push_back(v);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; written = 0; cons = 0; rp = 0; prev_hold = 1'b0;
        rst = 1'b1; start = 1'b0; line_done = 1'b0; win_ready = 1'b0;
        lb0_data = '0; lb1_data = '0; lb2_data = '0;

        // Reset state
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_oe", s_oe, 1'b0);
        check("rst_valid", s_vld, 1'b0);
        check("rst_consumed", s_lc, 1'b0);
        check("rst_frame_done", s_fd, 1'b0);
        check("rst_data", s_data, '0);
        check("rst_stall", s_sc, '0);
        check("rst_overflow", s_ov, 1'b0);
        check("rst_avail", s_av, 0);

        // Row 0 at full rate, stall on avail=2 in row 1, 5-cycle back-pressure, abort.
        //   rs st ld rdy  oe vld lc fd zero  av  sc  n
        add(0, 0, 1, 0,   0, 0, 0, 0, 0,    0, 0, 1);
        add(0, 0, 1, 0,   0, 0, 0, 0, 0,    1, 0, 1);
        add(0, 0, 1, 0,   0, 0, 0, 0, 0,    2, 0, 1);
        add(0, 1, 0, 1,   0, 0, 0, 0, 0,    3, 0, 1);
        add(0, 0, 0, 1,   1, 0, 0, 0, 0,    3, 0, 1);
        add(0, 0, 0, 1,   1, 1, 0, 0, 0,    3, 0, 6);
        add(0, 0, 0, 1,   1, 0, 0, 0, 0,    3, 0, 1);
        add(0, 0, 0, 1,   0, 0, 1, 0, 0,    3, 0, 1);
        add(0, 0, 0, 1,   0, 0, 0, 0, 0,    2, 0, 2);
        add(0, 0, 1, 1,   0, 0, 0, 0, 0,    2, 0, 1);
        add(0, 0, 0, 1,   1, 0, 0, 0, 0,    3, 0, 1);
        add(0, 0, 0, 1,   1, 1, 0, 0, 0,    3, 0, 1);
        for (int k = 0; k < 5; k++)
            add(0, 0, 0, 0, 0, 1, 0, 0, 0,  3, sc(k), 1);
        add(0, 0, 0, 1,   1, 1, 0, 0, 0,    3, sc(5), 2);
        add(1, 0, 0, 1,   0, 0, 0, 0, 1,    3, 0, 1);
        add(0, 0, 0, 1,   0, 0, 0, 0, 1,    0, 0, 1);
        add(0, 1, 0, 1,   0, 0, 0, 0, 0,    0, 0, 1);
        add(0, 0, 0, 1,   0, 0, 0, 0, 0,    0, 0, 2);

        new_frame();
        for (int i = 0; i < tv.size(); i++) begin
            cycle(tv[i].rs, tv[i].st, tv[i].ld, tv[i].rdy);
            check($sformatf("row%0d_oe", i), s_oe, tv[i].oe);
            check($sformatf("row%0d_valid", i), s_vld, tv[i].vld);
            check($sformatf("row%0d_consumed", i), s_lc, tv[i].lc);
            check($sformatf("row%0d_frame_done", i), s_fd, tv[i].fd);
            check($sformatf("row%0d_avail", i), s_av, tv[i].av);
            check($sformatf("row%0d_stall", i), s_sc, tv[i].sc);
            if (tv[i].zero) check($sformatf("row%0d_zero_data", i), s_data, '0);
        end
        check("stall_in_emit", s_st, int'(EMIT));

        // line_done together with line_consumed at avail=3, then saturation and overflow.
        do_reset();
        new_frame();
        repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (8) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        check("lc_align", s_lc, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("avail_hold", s_av, 3);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("avail_sat", s_av, 4);
        check("no_overflow_at_4", s_ov, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("overflow_set", s_ov, 1'b1);
        check("avail_stays_4", s_av, 4);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("overflow_sticky", s_ov, 1'b1);

        // Full frames: feed-ahead at full rate, then random line arrival and back-pressure.
        for (int m = 0; m < 3; m++) begin
            bit done;
            logic ld, rdy;
            done = 1'b0;
            do_reset();
            new_frame();
            cycle(1'b0, 1'b1, 1'b0, 1'b1);
            for (int k = 0; k < 3000 && !done; k++) begin
                ld  = (written < ROWS) && (written - cons < 4) && (m == 0 || $urandom_range(2) == 0);
                rdy = (m == 0) || ($urandom_range(3) != 0);
                cycle(1'b0, 1'b0, ld, rdy);
                if (s_fd) done = 1'b1;
            end
            if (!done) begin
                n_cmp++; n_err++;
                $display("FAIL frame%0d_timeout: got no frame_done, expected one within 3000 cycles", m);
            end
            check($sformatf("frame%0d_windows", m), n_acc, NWIN);
            check($sformatf("frame%0d_consumed", m), n_lc, ROWS - 2);
            check($sformatf("frame%0d_left", m), exp_q.size(), 0);
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
            check($sformatf("frame%0d_done_once", m), n_fd, 1);
            check($sformatf("frame%0d_idle", m), s_st, int'(IDLE));
            check($sformatf("frame%0d_overflow", m), s_ov, 1'b0);
            check($sformatf("frame%0d_avail", m), s_av, 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/window_reader.md
WINDOW_READER -- requirements
Module: window_reader

Interface
REQ-001 SHALL: the block has one clock (clk) and a synchronous, active-high reset (rst).
REQ-002 SHALL: parameter PIX_W, default 8, is the pixel width in bits.
REQ-003 SHALL: parameter LINE_W, default 8, is the pixels per line and the line buffer depth.
REQ-004 SHALL: parameter ROWS, default 8, is the lines per frame, with ROWS >= 3.
REQ-005 SHALL: clk  in  1  rising-edge clock.
REQ-006 SHALL: rst  in  1  synchronous, active-high reset.
REQ-007 SHALL: start  in  1  one-cycle pulse that begins a frame; ignored outside IDLE.
REQ-008 SHALL: line_done  in  1  pulse from the write side; one more full line is stored.
REQ-009 SHALL: lb0_data, lb1_data, lb2_data  in  3*PIX_W each  three consecutive pixels {p[c],p[c+1],p[c+2]} from the oldest, middle and newest line buffer.
REQ-010 SHALL: lb_oe  out  1  advances the read pointer of all three line buffers by one.
REQ-011 SHALL: line_consumed  out  1  one-cycle pulse; the oldest line may be overwritten.
REQ-012 SHALL: win_data  out  9*PIX_W  3x3 window {lb0_data,lb1_data,lb2_data}.
REQ-013 SHALL: win_valid  out  1  win_data holds a valid window.
REQ-014 SHALL: win_ready  in  1  the consumer accepts win_data when win_valid && win_ready.
REQ-015 SHALL: frame_done  out  1  one-cycle pulse after the last window row.
REQ-016 SHALL: overflow  out  1  sticky flag; line_done arrived while avail = 4.
REQ-017 SHALL: stall_cnt  out  16  stall statistic (see Configuration).

Function
REQ-018 SHALL: the FSM states are IDLE, EMIT, SKIP, ROW_END and DONE.
REQ-019 SHALL: IDLE -> EMIT on start; row_cnt and col_cnt clear to 0.
REQ-020 SHALL: avail is a 3-bit counter of stored lines.
REQ-021 SHALL: line_done increments avail, saturating at 4; a line_done at 4 sets overflow.
REQ-022 SHALL: simultaneous line_done and line_consumed leave avail unchanged.
REQ-023 SHALL: in EMIT, a capture occurs when avail >= 3 && (!win_valid || win_ready).
REQ-024 SHALL: a capture registers win_data, sets win_valid the next cycle, pulses lb_oe in the capture cycle and increments col_cnt.
REQ-025 SHALL: win_valid && !win_ready holds win_data and win_valid stable, with no lb_oe.
REQ-026 SHALL: win_valid clears after acceptance when no new capture occurs in the same cycle.
REQ-027 SHALL: back-to-back acceptance with capture sustains one window per cycle.
REQ-028 SHALL: after the (LINE_W-2)th capture, EMIT -> SKIP.
REQ-029 SHALL: SKIP lasts 2 cycles, pulses lb_oe in each and never asserts win_valid from new data, so the read pointer returns to 0.
REQ-030 SHALL: ROW_END lasts 1 cycle; it pulses line_consumed, increments row_cnt and clears col_cnt.
REQ-031 SHALL: ROW_END goes to DONE if row_cnt = ROWS-3, otherwise back to EMIT.
REQ-032 SHALL: DONE waits until win_valid = 0, pulses frame_done for 1 cycle, then goes to IDLE.
REQ-033 SHALL: the frame produces (ROWS-2)*(LINE_W-2) windows, each a 3x3 window at (row_cnt, col_cnt).

Reset
REQ-034 SHALL: while rst = 1 at a clock edge, the state goes to IDLE and avail, counters and overflow clear to 0.
REQ-035 SHALL: while rst = 1, win_valid, lb_oe, line_consumed and frame_done are 0; win_data = 0; stall_cnt = 0.
REQ-036 SHALL: rst asserted mid-frame aborts the frame with no frame_done, and any pending window is dropped.

Configuration
REQ-037 SHALL: with WINDOW_READER_STATS_EN defined, stall_cnt counts cycles with win_valid && !win_ready, saturates at 16'hFFFF and clears on start or rst.
REQ-038 SHALL: without WINDOW_READER_STATS_EN, stall_cnt is tied to 0 and the counter logic is absent.

Structure
REQ-039 SHALL: package conv_pkg holds PIX_W, LINE_W, ROWS, the state typedef and the avail maximum of 4, shared with the write side.
REQ-040 SHALL: sub-module line_credit holds avail, its saturation and the overflow flag.

Verification
REQ-041 SHALL: reset, 3 line_done pulses, start with win_ready = 1 -> 6 windows on consecutive cycles, 2 SKIP lb_oe pulses, one line_consumed, avail = 2.
REQ-042 SHALL: avail = 2 in EMIT -> no capture and no lb_oe until the next line_done; capture occurs 1 cycle after avail = 3.
REQ-043 SHALL: win_ready = 0 for 5 cycles with a window pending -> win_data stable, no lb_oe, stall_cnt = 5 (STATS_EN defined) or 0 (undefined).
REQ-044 SHALL: a full 8x8 frame with line_done fed ahead -> 36 windows, 6 line_consumed, one frame_done, return to IDLE.
REQ-045 SHALL: line_done and line_consumed in the same cycle at avail = 3 -> avail stays 3; a 5th line_done at avail = 4 -> overflow = 1.
REQ-046 SHALL: rst after window 3 of row 1 -> all outputs 0 the next cycle; a new start with avail = 0 stalls in EMIT.
